logic_unit_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's combinational two-input gate block.
- Applies one of eight bitwise logic operations to WIDTH-bit operand pairs selected per transaction by an opcode.
- Buffers results in a 2-entry output queue behind valid/ready handshakes on both sides.
- Reports zero/parity flags per result and keeps a saturating completed-transaction counter.
- Sits between a producer and consumer that both use standard valid/ready streaming.

---
 rtl/logic_unit_pipe.sv | 105 ++++++++++
 tb/tb_logic_unit_pipe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit: result + zero/parity computed at push, buffered in a 2-entry queue.
// One-cycle push-to-out_valid latency; in_ready/out_valid depend on registered occupancy only.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNT_W-1:0] txn_count
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             parity;
  } entry_t;

  localparam entry_t           ENTRY_RST = '{data: '0, zero: 1'b1, parity: 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [1:0]       occ_q, occ_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  entry_t           mem_q [2];

  logic [WIDTH-1:0] res;
  entry_t           new_entry;
  entry_t           head;
  logic             push;
  logic             pop;

  always_comb begin
    res = '0;
    case (in_op)
      3'b000: res = ~in_a;
      3'b001: res = in_a & in_b;
      3'b010: res = ~(in_a & in_b);
      3'b011: res = in_a | in_b;
      3'b100: res = ~(in_a | in_b);
      3'b101: res = in_a ^ in_b;
      3'b110: res = ~(in_a ^ in_b);
      3'b111: res = in_a;
      default: res = '0;
    endcase
  end

  assign new_entry = '{data: res, zero: (res == '0), parity: ^res};

  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop) rd_ptr_d = ~rd_ptr_q;
    if (pop && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      mem_q[0] <= ENTRY_RST;
      mem_q[1] <= ENTRY_RST;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) mem_q[wr_ptr_q] <= new_entry;
    end
  end

  // Empty queue shows the reset values regardless of stale storage.
  assign head       = mem_q[rd_ptr_q];
  assign out_data   = out_valid ? head.data   : '0;
  assign out_zero   = out_valid ? head.zero   : 1'b1;
  assign out_parity = out_valid ? head.parity : 1'b0;
  assign txn_count  = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: reset, opcode sweep, backpressure, streaming,
// counter saturation (CNT_W=2 instance) and asynchronous mid-operation reset.
module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_a, in_b, out_data;
  logic [2:0]  in_op;
  logic        out_zero, out_parity;
  logic [15:0] txn_count;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [7:0]  s_in_a, s_in_b, s_out_data;
  logic [2:0]  s_in_op;
  logic        s_out_zero, s_out_parity;
  logic [1:0]  s_txn_count;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .out_parity(out_parity),
    .txn_count(txn_count)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_op(s_in_op),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_zero(s_out_zero), .out_parity(s_out_parity),
    .txn_count(s_txn_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_op    = op;
  endtask

  // Hand-computed results for A=A5, B=3C, ops 000..111; every one has even parity.
  logic [7:0] sweep_exp [8] = '{8'h5A, 8'h24, 8'hDB, 8'hBD, 8'h42, 8'h99, 8'h66, 8'hA5};
  logic       sweep_par [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  // PASS-A stream with mixed parity: 07,80,01,3F,FE
  logic [7:0] strm_dat  [5] = '{8'h07, 8'h80, 8'h01, 8'h3F, 8'hFE};
  logic       strm_par  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [1:0] sat_exp   [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 3'b000);
    out_ready   = 1'b0;
    s_in_valid  = 1'b0;
    s_in_a      = 8'h00;
    s_in_b      = 8'h00;
    s_in_op     = 3'b111;
    s_out_ready = 1'b1;

    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_zero", out_zero, 1);
    chk("rst_out_parity", out_parity, 0);
    chk("rst_txn_count", txn_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);

    // Opcode sweep, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'hA5, 8'h3C, 3'(i));
      tick();
      chk($sformatf("sweep%0d_valid", i), out_valid, 1);
      chk($sformatf("sweep%0d_data", i), out_data, sweep_exp[i]);
      chk($sformatf("sweep%0d_parity", i), out_parity, sweep_par[i]);
      chk($sformatf("sweep%0d_zero", i), out_zero, 0);
      chk($sformatf("sweep%0d_in_ready", i), in_ready, 1);
    end
    drive(1'b0, 8'h00, 8'h00, 3'b000);
    tick();
    chk("sweep_drain_valid", out_valid, 0);
    chk("sweep_txn_count", txn_count, 8);

    // Backpressure: three AND transactions into a stalled consumer
    out_ready = 1'b0;
    drive(1'b1, 8'hFF, 8'h0F, 3'b001);
    tick();
    chk("bp_push1_in_ready", in_ready, 1);
    chk("bp_push1_data", out_data, 8'h0F);
    drive(1'b1, 8'hF0, 8'h0F, 3'b001);
    tick();
    chk("bp_push2_in_ready", in_ready, 0);
    chk("bp_push2_head", out_data, 8'h0F);
    drive(1'b1, 8'h11, 8'h11, 3'b001);
    tick();
    chk("bp_hold_in_ready", in_ready, 0);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_head", out_data, 8'h0F);
    chk("bp_hold_count", txn_count, 8);
    out_ready = 1'b1;
    tick();
    chk("bp_pop1_data", out_data, 8'h00);
    chk("bp_pop1_zero", out_zero, 1);
    chk("bp_pop1_in_ready", in_ready, 1);
    tick();
    chk("bp_pop2_data", out_data, 8'h11);
    chk("bp_pop2_zero", out_zero, 0);
    drive(1'b0, 8'h00, 8'h00, 3'b000);
    tick();
    chk("bp_drain_valid", out_valid, 0);
    chk("bp_txn_count", txn_count, 11);

    // Simultaneous push/pop at occupancy 1
    out_ready = 1'b0;
    drive(1'b1, strm_dat[0], 8'h00, 3'b111);
    tick();
    chk("sp_prefill_data", out_data, strm_dat[0]);
    chk("sp_prefill_parity", out_parity, strm_par[0]);
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      drive(1'b1, strm_dat[k], 8'h00, 3'b111);
      tick();
      chk($sformatf("sp%0d_in_ready", k), in_ready, 1);
      chk($sformatf("sp%0d_valid", k), out_valid, 1);
      chk($sformatf("sp%0d_data", k), out_data, strm_dat[k]);
      chk($sformatf("sp%0d_parity", k), out_parity, strm_par[k]);
    end
    drive(1'b0, 8'h00, 8'h00, 3'b000);
    tick();
    chk("sp_drain_valid", out_valid, 0);
    chk("sp_txn_count", txn_count, 16);

    // Saturation on the CNT_W=2 instance
    s_in_valid = 1'b1;
    tick();
    chk("sat_first_push_count", s_txn_count, 0);
    for (int n = 0; n < 5; n++) begin
      if (n == 4) s_in_valid = 1'b0;
      tick();
      chk($sformatf("sat_count%0d", n + 1), s_txn_count, sat_exp[n]);
    end
    tick();
    chk("sat_drained", s_out_valid, 0);

    // Mid-operation asynchronous reset with a full queue
    out_ready = 1'b0;
    drive(1'b1, 8'hAA, 8'h0F, 3'b001);
    tick();
    drive(1'b1, 8'hAA, 8'hFF, 3'b011);
    tick();
    chk("mr_full_in_ready", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_async_valid", out_valid, 0);
    chk("mr_async_in_ready", in_ready, 1);
    chk("mr_async_data", out_data, 8'h00);
    chk("mr_async_zero", out_zero, 1);
    chk("mr_async_count", txn_count, 0);
    drive(1'b1, 8'h3C, 8'h00, 3'b000);
    tick();
    chk("mr_no_push_in_reset", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mr_new_valid", out_valid, 1);
    chk("mr_new_data", out_data, 8'hC3);
    chk("mr_new_in_ready", in_ready, 1);
    drive(1'b0, 8'h00, 8'h00, 3'b000);
    out_ready = 1'b1;
    tick();
    chk("mr_alone_valid", out_valid, 0);
    chk("mr_alone_count", txn_count, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
